accel_ctrl_multi: RTL

Parametrised successor to the accelerator front-end controller. Sits between the processor port and the level-control blocks, accepting the same command protocol: 00 nop, 01 start, 10 read, 11 stop. It buffers a cipher text of configurable length and packs it into wide beats, then streams those beats to level control with a valid/ready handshake before firing `startLC`. It also serves processor reads of the cipher buffer, performance counters and key words, and adds abort, sequencing-error and status behaviour.

---
 rtl/accel_ctrl_multi.sv | 134 +++++++++++++
 1 files changed

// File: rtl/accel_ctrl_multi.sv
// Accelerator front-end controller: buffers a cipher text from the processor,
// streams it as wide beats to level control over valid/ready, then fires
// startLC. Also serves processor reads of the buffer and perf-count/key words.
module accel_ctrl_multi #(
  parameter int DW       = 16,
  parameter int CT_WORDS = 16,
  parameter int LC_W     = 64,
  parameter int PK_AW    = 4,
  localparam int WPB     = LC_W / DW,
  localparam int NBEATS  = CT_WORDS / WPB,
  localparam int CA      = $clog2(CT_WORDS),
  localparam int AW      = ((CA > PK_AW) ? CA : PK_AW) + 1,
  localparam int LV      = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        control,
  input  logic [AW-1:0]     address,
  input  logic [DW-1:0]     data,
  input  logic [DW-1:0]     pckeydata,
  output logic [PK_AW-1:0]  pckeyaddr,
  output logic [DW-1:0]     dataToProc,
  output logic [LC_W-1:0]   dataToLC,
  output logic [LV-1:0]     levels,
  output logic              lc_valid,
  input  logic              lc_ready,
  output logic              startLC,
  output logic              stop,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, RUN} state_t;

  state_t            state, state_next;
  logic [CA-1:0]     wc;
  logic [LV-1:0]     bc;
  logic [DW-1:0]     mem [CT_WORDS];
  logic [LC_W-1:0]   cur_beat;
  logic              cmd_nop, cmd_start, cmd_read, cmd_stop;
  logic              cipher_wr, wr_ok, wr_bad, last_word, last_beat, hs;

  assign cmd_nop   = (control == 2'b00);
  assign cmd_start = (control == 2'b01);
  assign cmd_read  = (control == 2'b10);
  assign cmd_stop  = (control == 2'b11);

  assign cipher_wr = (state == LOAD) && cmd_nop && !address[AW-1];
  assign wr_ok     = cipher_wr && (address[CA-1:0] == wc);
  assign wr_bad    = cipher_wr && (address[CA-1:0] != wc);
  assign last_word = (wc == CA'(CT_WORDS - 1));
  assign last_beat = (bc == LV'(NBEATS - 1));
  assign hs        = (state == ISSUE) && lc_ready;

  assign pckeyaddr = address[PK_AW-1:0];

  // Gather the beat selected by bc; word 0 of a beat sits in the low bits
  always_comb begin
    cur_beat = '0;
    for (int unsigned w = 0; w < WPB; w++)
      cur_beat[w*DW +: DW] = mem[CA'(32'(bc) * WPB + w)];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic; stop from LOAD/ISSUE is an abort
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (cmd_start) state_next = LOAD;
      LOAD:  if (cmd_stop) state_next = IDLE;
             else if (wr_ok && last_word) state_next = ISSUE;
      ISSUE: if (cmd_stop) state_next = IDLE;
             else if (hs && last_beat) state_next = RUN;
      RUN:   if (cmd_stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs; beat bus is forced to zero whenever no beat is offered
  always_comb begin
    lc_valid = (state == ISSUE);
    busy     = (state != IDLE);
    levels   = bc;
    dataToLC = lc_valid ? cur_beat : '0;
  end

  // Cipher buffer, deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (rst && wr_ok) mem[address[CA-1:0]] <= data;
  end

  // Word and beat counters; both clear whenever their phase is left
  always_ff @(posedge clk) begin
    if (!rst) begin
      wc <= '0;
      bc <= '0;
    end else begin
      if (state_next != LOAD) wc <= '0;
      else if (wr_ok)         wc <= wc + CA'(1);
      if (state_next != ISSUE) bc <= '0;
      else if (hs)             bc <= bc + LV'(1);
    end
  end

  // Single-cycle pulses; startLC is suppressed if a stop coincides with the final handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      startLC <= 1'b0;
      stop    <= 1'b0;
    end else begin
      startLC <= hs && last_beat && !cmd_stop;
      stop    <= cmd_stop;
    end
  end

  // Sticky sequencing error: start in IDLE clears it, misplaced start or write sets it
  always_ff @(posedge clk) begin
    if (!rst)                          err <= 1'b0;
    else if (cmd_start)                err <= (state != IDLE);
    else if (wr_bad)                   err <= 1'b1;
  end

  // Processor read port, one cycle latency, held when not reading
  always_ff @(posedge clk) begin
    if (!rst)          dataToProc <= '0;
    else if (cmd_read) dataToProc <= address[AW-1] ? pckeydata : mem[address[CA-1:0]];
  end

endmodule
